// File: rtl/painter_pkg.sv
// Shared definitions for the multi-pipe painter: state encoding, colours,
// default screen geometry and the pipe-gap row test.
package painter_pkg;

   localparam logic [2:0] StIdle      = 3'd0;
   localparam logic [2:0] StEraseBox  = 3'd1;
   localparam logic [2:0] StErasePipe = 3'd2;
   localparam logic [2:0] StLatch     = 3'd3;
   localparam logic [2:0] StDrawBox   = 3'd4;
   localparam logic [2:0] StDrawPipe  = 3'd5;
   localparam logic [2:0] StDone      = 3'd6;

   localparam logic [2:0] BLACK = 3'b000;
   localparam logic [2:0] GREEN = 3'b010;
   localparam logic [2:0] WHITE = 3'b111;

   localparam int unsigned DEF_SCREEN_W = 160;
   localparam int unsigned DEF_SCREEN_H = 120;
   localparam int unsigned DEF_GAP_H    = 30;

   // Widened to 9 bits so gap_top + gap_h cannot wrap past the last row.
   function automatic logic row_in_gap(input logic [6:0] row, input logic [6:0] gap_top,
                                       input int unsigned gap_h);
      return ({2'b00, row} >= {2'b00, gap_top}) &&
             ({2'b00, row} < ({2'b00, gap_top} + 9'(gap_h)));
   endfunction

endpackage

// File: rtl/column_scanner.sv
// Row/pipe stepper shared by the erase and draw pipe phases. Outputs describe the
// row about to be painted (next-state values) so the top can register them directly.
module column_scanner
   import painter_pkg::*;
#(
   parameter int unsigned NUM_PIPES = 2,
   parameter int unsigned SCREEN_W  = DEF_SCREEN_W,
   parameter int unsigned SCREEN_H  = DEF_SCREEN_H,
   parameter int unsigned GAP_H     = DEF_GAP_H,
   parameter int unsigned PIPE_W    = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   start_i,
   input  logic                   step_i,
   input  logic [NUM_PIPES*8-1:0] pipe_x_i,
   input  logic [NUM_PIPES*7-1:0] pipe_gap_y_i,
   output logic                   last_o,
   output logic [7:0]             col_x_o,
   output logic [6:0]             row_o,
   output logic                   plot_mask_o
);

   logic [6:0]        row_q, row_d;
   logic [PIPE_W-1:0] pipe_q, pipe_d;
   logic [6:0]        gap_top;

   assign last_o = (row_q == 7'(SCREEN_H - 1)) && (pipe_q == PIPE_W'(NUM_PIPES - 1));
   assign row_o  = row_d;

   always_comb begin
      row_d  = row_q;
      pipe_d = pipe_q;
      if (start_i) begin
         row_d  = '0;
         pipe_d = '0;
      end else if (step_i) begin
         if (row_q == 7'(SCREEN_H - 1)) begin
            row_d  = '0;
            pipe_d = pipe_q + 1'b1;
         end else begin
            row_d = row_q + 7'd1;
         end
      end
   end

   always_comb begin
      col_x_o = '0;
      gap_top = '0;
      for (int i = 0; i < NUM_PIPES; i++) begin
         if (pipe_d == PIPE_W'(i)) begin
            col_x_o = pipe_x_i[8*i +: 8];
            gap_top = pipe_gap_y_i[7*i +: 7];
         end
      end
      plot_mask_o = ({1'b0, col_x_o} < 9'(SCREEN_W)) && !row_in_gap(row_d, gap_top, GAP_H);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         row_q  <= '0;
         pipe_q <= '0;
      end else begin
         row_q  <= row_d;
         pipe_q <= pipe_d;
      end
   end

endmodule

// File: rtl/multi_pipe_painter.sv
// Frame painter: erases the previous box/pipe snapshot, latches new positions, redraws.
// Box phases exist only when MULTI_PIPE_PAINTER_BOX_EN is defined.
module multi_pipe_painter
   import painter_pkg::*;
#(
   parameter int unsigned NUM_PIPES = 2,
   parameter int unsigned SCREEN_W  = DEF_SCREEN_W,
   parameter int unsigned SCREEN_H  = DEF_SCREEN_H,
   parameter int unsigned GAP_H     = DEF_GAP_H,
   parameter int unsigned BOX_X     = 4
) (
   input  logic                   CLOCK_50,
   input  logic                   reset,
   input  logic                   game_pulse,
   input  logic [6:0]             box_y,
   input  logic [NUM_PIPES*8-1:0] pipe_x,
   input  logic [NUM_PIPES*7-1:0] pipe_gap_y,
   output logic                   plot,
   output logic [7:0]             x,
   output logic [6:0]             y,
   output logic [2:0]             colour,
   output logic                   busy,
   output logic                   frame_done,
   output logic                   overrun
);

   logic [2:0]             state_q, state_d;
   logic                   pending_q, pending_d;
   logic                   snap_valid_q, snap_valid_d;
   logic [NUM_PIPES*8-1:0] snap_pipe_x_q, snap_pipe_x_d;
   logic [NUM_PIPES*7-1:0] snap_gap_q, snap_gap_d;
   logic                   plot_q, plot_d;
   logic [7:0]             x_q, x_d;
   logic [6:0]             y_q, y_d;
   logic [2:0]             colour_q, colour_d;
   logic                   frame_done_q, frame_done_d;
   logic                   overrun_q, overrun_d;
   logic                   start_frame;
   logic                   scan_start, scan_step, scan_last, scan_mask;
   logic [7:0]             scan_x;
   logic [6:0]             scan_row;

`ifdef MULTI_PIPE_PAINTER_BOX_EN
   logic [6:0] snap_box_y_q, snap_box_y_d;
   logic [3:0] box_cnt_q, box_cnt_d;
   logic [7:0] box_row_p1;
`else
   logic unused_box;
   assign unused_box = ^{box_y, 8'(BOX_X)};
`endif

   column_scanner #(
      .NUM_PIPES (NUM_PIPES),
      .SCREEN_W  (SCREEN_W),
      .SCREEN_H  (SCREEN_H),
      .GAP_H     (GAP_H)
   ) u_scanner (
      .clk_i        (CLOCK_50),
      .reset_i      (reset),
      .start_i      (scan_start),
      .step_i       (scan_step),
      .pipe_x_i     (snap_pipe_x_d),
      .pipe_gap_y_i (snap_gap_d),
      .last_o       (scan_last),
      .col_x_o      (scan_x),
      .row_o        (scan_row),
      .plot_mask_o  (scan_mask)
   );

   always_comb begin
      state_d      = state_q;
      pending_d    = pending_q;
      snap_valid_d = snap_valid_q;
      snap_pipe_x_d = snap_pipe_x_q;
      snap_gap_d   = snap_gap_q;
      overrun_d    = 1'b0;
      frame_done_d = 1'b0;
      start_frame  = 1'b0;
      scan_start   = 1'b0;
      scan_step    = 1'b0;
`ifdef MULTI_PIPE_PAINTER_BOX_EN
      snap_box_y_d = snap_box_y_q;
      box_cnt_d    = box_cnt_q;
`endif
      // Only one request can wait behind the current frame; extras are dropped.
      if (state_q != StIdle && game_pulse) begin
         if (pending_q) overrun_d = 1'b1;
         else           pending_d = 1'b1;
      end
      case (state_q)
         StIdle: start_frame = game_pulse || pending_q;
`ifdef MULTI_PIPE_PAINTER_BOX_EN
         StEraseBox: begin
            if (box_cnt_q == 4'd8) begin
               state_d    = StErasePipe;
               scan_start = 1'b1;
            end else begin
               box_cnt_d = box_cnt_q + 4'd1;
            end
         end
         StDrawBox: begin
            if (box_cnt_q == 4'd8) begin
               state_d    = StDrawPipe;
               scan_start = 1'b1;
            end else begin
               box_cnt_d = box_cnt_q + 4'd1;
            end
         end
`endif
         StErasePipe: begin
            if (scan_last) state_d = StLatch;
            else           scan_step = 1'b1;
         end
         StLatch: begin
            snap_valid_d  = 1'b1;
            snap_pipe_x_d = pipe_x;
            snap_gap_d    = pipe_gap_y;
`ifdef MULTI_PIPE_PAINTER_BOX_EN
            snap_box_y_d = box_y;
            state_d      = StDrawBox;
            box_cnt_d    = '0;
`else
            state_d    = StDrawPipe;
            scan_start = 1'b1;
`endif
         end
         StDrawPipe: begin
            if (scan_last) begin
               state_d      = StDone;
               frame_done_d = 1'b1;
            end else begin
               scan_step = 1'b1;
            end
         end
         StDone: begin
            if (pending_q) start_frame = 1'b1;
            else           state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (start_frame) begin
         pending_d = 1'b0;
         if (snap_valid_q) begin
`ifdef MULTI_PIPE_PAINTER_BOX_EN
            state_d   = StEraseBox;
            box_cnt_d = '0;
`else
            state_d    = StErasePipe;
            scan_start = 1'b1;
`endif
         end else begin
            state_d = StLatch;
         end
      end
   end

   // Pixel outputs follow the next state so each state's pixel is visible while in it.
   always_comb begin
      plot_d   = 1'b0;
      x_d      = x_q;
      y_d      = y_q;
      colour_d = colour_q;
`ifdef MULTI_PIPE_PAINTER_BOX_EN
      box_row_p1 = '0;
`endif
      case (state_d)
`ifdef MULTI_PIPE_PAINTER_BOX_EN
         StEraseBox, StDrawBox: begin
            box_row_p1 = {1'b0, snap_box_y_d} + 8'(box_cnt_d / 4'd3);
            if (box_row_p1 != 8'd0 && box_row_p1 <= 8'(SCREEN_H)) begin
               plot_d   = 1'b1;
               x_d      = 8'(BOX_X - 1) + 8'(box_cnt_d % 4'd3);
               y_d      = 7'(box_row_p1 - 8'd1);
               colour_d = (state_d == StDrawBox) ? WHITE : BLACK;
            end
         end
`endif
         StErasePipe, StDrawPipe: begin
            if (scan_mask) begin
               plot_d   = 1'b1;
               x_d      = scan_x;
               y_d      = scan_row;
               colour_d = (state_d == StDrawPipe) ? GREEN : BLACK;
            end
         end
         default: plot_d = 1'b0;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q       <= StIdle;
         pending_q     <= 1'b0;
         snap_valid_q  <= 1'b0;
         snap_pipe_x_q <= '0;
         snap_gap_q    <= '0;
         plot_q        <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         colour_q      <= BLACK;
         frame_done_q  <= 1'b0;
         overrun_q     <= 1'b0;
`ifdef MULTI_PIPE_PAINTER_BOX_EN
         snap_box_y_q  <= '0;
         box_cnt_q     <= '0;
`endif
      end else begin
         state_q       <= state_d;
         pending_q     <= pending_d;
         snap_valid_q  <= snap_valid_d;
         snap_pipe_x_q <= snap_pipe_x_d;
         snap_gap_q    <= snap_gap_d;
         plot_q        <= plot_d;
         x_q           <= x_d;
         y_q           <= y_d;
         colour_q      <= colour_d;
         frame_done_q  <= frame_done_d;
         overrun_q     <= overrun_d;
`ifdef MULTI_PIPE_PAINTER_BOX_EN
         snap_box_y_q  <= snap_box_y_d;
         box_cnt_q     <= box_cnt_d;
`endif
      end
   end

   assign plot       = plot_q;
   assign x          = x_q;
   assign y          = y_q;
   assign colour     = colour_q;
   assign busy       = (state_q != StIdle);
   assign frame_done = frame_done_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_multi_pipe_painter.sv
// Directed bench for multi_pipe_painter (default parameters); box expectations
// follow MULTI_PIPE_PAINTER_BOX_EN.
module tb_multi_pipe_painter;

`ifdef MULTI_PIPE_PAINTER_BOX_EN
   localparam int BOX = 9;
`else
   localparam int BOX = 0;
`endif
   localparam int PIPE_CYC = 240;
   localparam int L_FIRST  = 1 + BOX + PIPE_CYC + 1;
   localparam int L_FULL   = 2 * BOX + 2 * PIPE_CYC + 2;

   logic        CLOCK_50 = 1'b0;
   logic        reset = 1'b1;
   logic        game_pulse = 1'b0;
   logic [6:0]  box_y = 7'd60;
   logic [15:0] pipe_x = {8'd100, 8'd50};
   logic [13:0] pipe_gap_y = {7'd10, 7'd40};
   logic        plot, busy, frame_done, overrun;
   logic [7:0]  x;
   logic [6:0]  y;
   logic [2:0]  colour;

   int n_cmp = 0, n_fail = 0;
   int cyc, n_plot, n_white, n_black, n_green, n_boxcol, n_done, n_ovr, n_busy_low;
   int hold_viol, gap_hits, first_plot, done_at, last_done_at;
   int g_cnt[256], k_cnt[256], g_maxy[256];
   int chk_x[2], chk_lo[2], chk_hi[2];
   int inj_a = 0, inj_b = 0, scr_at = 0;
   logic [7:0] prev_x;
   logic [6:0] prev_y;

   multi_pipe_painter u_dut (
      .CLOCK_50   (CLOCK_50),
      .reset      (reset),
      .game_pulse (game_pulse),
      .box_y      (box_y),
      .pipe_x     (pipe_x),
      .pipe_gap_y (pipe_gap_y),
      .plot       (plot),
      .x          (x),
      .y          (y),
      .colour     (colour),
      .busy       (busy),
      .frame_done (frame_done),
      .overrun    (overrun)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic start_pulse();
      @(posedge CLOCK_50);
      #1 game_pulse = 1'b1;
      @(posedge CLOCK_50);
      #1 game_pulse = 1'b0;
   endtask

   // Samples on falling edges; cycle 1 is the cycle after the pulse was sampled.
   task automatic collect(input int max_cyc, input int done_target, input int stop_pix);
      cyc = 0; n_plot = 0; n_white = 0; n_black = 0; n_green = 0; n_boxcol = 0;
      n_done = 0; n_ovr = 0; n_busy_low = 0; hold_viol = 0; gap_hits = 0;
      first_plot = -1; done_at = -1; last_done_at = -1;
      for (int i = 0; i < 256; i++) begin
         g_cnt[i] = 0; k_cnt[i] = 0; g_maxy[i] = -1;
      end
      prev_x = x;
      prev_y = y;
      for (int c = 0; c < max_cyc; c++) begin
         @(negedge CLOCK_50);
         cyc++;
         if ((inj_a != 0 && cyc == inj_a) || (inj_b != 0 && cyc == inj_b)) game_pulse = 1'b1;
         if ((inj_a != 0 && cyc == inj_a + 1) || (inj_b != 0 && cyc == inj_b + 1))
            game_pulse = 1'b0;
         if (scr_at != 0 && cyc == scr_at) begin
            box_y = 7'd77;
            pipe_x = {8'd60, 8'd70};
            pipe_gap_y = '0;
         end
         if (plot) begin
            n_plot++;
            if (first_plot < 0) first_plot = cyc;
            if (colour == 3'b111) n_white++;
            if (colour == 3'b000) begin n_black++; k_cnt[x]++; end
            if (colour == 3'b010) begin
               n_green++; g_cnt[x]++;
               if (int'(y) > g_maxy[x]) g_maxy[x] = int'(y);
            end
            if (x >= 8'd3 && x <= 8'd5) n_boxcol++;
            for (int p = 0; p < 2; p++)
               if (int'(x) == chk_x[p] && int'(y) >= chk_lo[p] && int'(y) <= chk_hi[p])
                  gap_hits++;
         end else if (x !== prev_x || y !== prev_y) begin
            hold_viol++;
         end
         prev_x = x;
         prev_y = y;
         if (!busy) n_busy_low++;
         if (overrun) n_ovr++;
         if (frame_done) begin
            n_done++;
            if (n_done == 1) done_at = cyc;
            last_done_at = cyc;
            if (done_target != 0 && n_done >= done_target) break;
         end
         if (stop_pix != 0 && n_plot == stop_pix) break;
      end
   endtask

   initial begin
      chk_x  = '{50, 100};
      chk_lo = '{40, 10};
      chk_hi = '{69, 39};

      repeat (3) @(posedge CLOCK_50);
      #1;
      check("rst_plot", int'(plot), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_x", int'(x), 0);
      check("rst_y", int'(y), 0);
      check("rst_colour", int'(colour), 0);
      check("rst_done", int'(frame_done), 0);
      check("rst_overrun", int'(overrun), 0);
      reset = 1'b0;

      // First frame: no snapshot yet, so no erase.
      start_pulse();
      collect(L_FULL + 20, 1, 0);
      check("f1_done_at", done_at, L_FIRST);
      check("f1_first_plot", first_plot, 2);
      check("f1_black", n_black, 0);
      check("f1_green50", g_cnt[50], 90);
      check("f1_green100", g_cnt[100], 90);
      check("f1_white", n_white, BOX);
      check("f1_boxcol", n_boxcol, BOX);
      check("f1_gap_hits", gap_hits, 0);

      // Second frame: erase then redraw the same snapshot.
      start_pulse();
      collect(L_FULL + 20, 1, 0);
      check("f2_done_at", done_at, L_FULL);
      check("f2_first_plot", first_plot, 1);
      check("f2_black50", k_cnt[50], 90);
      check("f2_black100", k_cnt[100], 90);
      check("f2_green50", g_cnt[50], 90);
      check("f2_green100", g_cnt[100], 90);
      check("f2_gap_hits", gap_hits, 0);
      check("f2_boxcol", n_boxcol, 2 * BOX);
      check("f2_hold", hold_viol, 0);
      check("f2_busy_low", n_busy_low, 0);

      // Clipping, with inputs scrambled after LATCH.
      box_y = 7'd0;
      pipe_x = {8'd30, 8'd200};
      pipe_gap_y = {7'd110, 7'd0};
      chk_x  = '{30, 200};
      chk_lo = '{110, 0};
      chk_hi = '{119, 119};
      scr_at = BOX + PIPE_CYC + 10;
      start_pulse();
      collect(L_FULL + 20, 1, 0);
      scr_at = 0;
      check("f3_done_at", done_at, L_FULL);
      check("f3_white", n_white, (BOX > 0) ? 6 : 0);
      check("f3_black", n_black, 180 + BOX);
      check("f3_green30", g_cnt[30], 110);
      check("f3_maxy30", g_maxy[30], 109);
      check("f3_x200", g_cnt[200] + k_cnt[200], 0);
      check("f3_gap_hits", gap_hits, 0);
      check("f3_scramble", g_cnt[60] + g_cnt[70], 0);
      check("f3_hold", hold_viol, 0);

      // Back-to-back frames: one pending request, one dropped.
      box_y = 7'd60;
      pipe_x = {8'd100, 8'd50};
      pipe_gap_y = {7'd10, 7'd40};
      inj_a = 20;
      inj_b = 40;
      start_pulse();
      collect(3 * L_FULL, 2, 0);
      inj_a = 0;
      inj_b = 0;
      check("b2b_dones", n_done, 2);
      check("b2b_first_done", done_at, L_FULL);
      check("b2b_second_done", last_done_at, 2 * L_FULL);
      check("b2b_overrun", n_ovr, 1);
      check("b2b_busy_low", n_busy_low, 0);

      // Reset at the 100th pixel.
      start_pulse();
      collect(L_FULL + 20, 0, 100);
      check("abort_plots", n_plot, 100);
      check("abort_pre_done", n_done, 0);
      reset = 1'b1;
      @(negedge CLOCK_50);
      check("abort_plot", int'(plot), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_frame_done", int'(frame_done), 0);
      reset = 1'b0;
      collect(400, 0, 0);
      check("abort_no_done", n_done, 0);
      check("abort_no_plot", n_plot, 0);
      start_pulse();
      collect(L_FULL + 20, 1, 0);
      check("post_abort_done_at", done_at, L_FIRST);
      check("post_abort_black", n_black, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
